act_pingpong_buffer: RTL



---
 rtl/act_pingpong_buffer_pkg.sv | 22 ++
 rtl/act_pingpong_buffer_if.sv | 42 ++++
 rtl/act_pingpong_buffer_skew_line.sv | 33 +++
 rtl/act_pingpong_buffer.sv | 108 ++++++++++
 4 files changed

// File: rtl/act_pingpong_buffer_pkg.sv
// ============================================================================
// Module      : act_pingpong_buffer_pkg
// Description : Shared defaults and count-width helper for the activation
//               and weight buffers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package act_pingpong_buffer_pkg;

    localparam int c_DEFAULT_DATA_WIDTH = 8;
    localparam int c_DEFAULT_LANES      = 4;
    localparam int c_DEFAULT_DEPTH      = 16;

    // Width needed to hold a count from 0 up to and including depth.
    function automatic int f_cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/act_pingpong_buffer_if.sv
// ============================================================================
// Module      : act_pingpong_buffer_if
// Description : Host-stream, swap/replay control and skewed array-feed bus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface act_pingpong_buffer_if
    import act_pingpong_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = c_DEFAULT_DATA_WIDTH,
    parameter int LANES      = c_DEFAULT_LANES,
    parameter int DEPTH      = c_DEFAULT_DEPTH
);
    localparam int c_CNT_W = f_cnt_width(DEPTH);

    logic [LANES*DATA_WIDTH-1:0] in_data;
    logic                        in_valid;
    logic                        in_ready;
    logic                        swap_req;
    logic                        swap_ack;
    logic                        replay;
    logic                        read_en;
    logic                        rd_empty;
    logic [LANES*DATA_WIDTH-1:0] out_data;
    logic [LANES-1:0]            out_valid;
    logic [c_CNT_W-1:0]          wr_count;
    logic                        active_bank;

    modport master (
        output in_data, in_valid, swap_req, replay, read_en,
        input  in_ready, swap_ack, rd_empty, out_data, out_valid, wr_count, active_bank
    );

    modport slave (
        input  in_data, in_valid, swap_req, replay, read_en,
        output in_ready, swap_ack, rd_empty, out_data, out_valid, wr_count, active_bank
    );

endinterface

`default_nettype wire

// File: rtl/act_pingpong_buffer_skew_line.sv
// ============================================================================
// Module      : act_pingpong_buffer_skew_line
// Description : Free-running N-stage delay line (data plus valid bit).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module act_pingpong_buffer_skew_line #(
    parameter int N     = 1,
    parameter int WIDTH = 9
) (
    input  wire              clk,
    input  wire              rst_n,
    input  wire  [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_pipe [N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= i_d;
            for (int i = 1; i < N; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign o_q = r_pipe[N-1];

endmodule

`default_nettype wire

// File: rtl/act_pingpong_buffer.sv
// ============================================================================
// Module      : act_pingpong_buffer
// Description : Two-bank ping-pong activation buffer with replay and
//               optional diagonal lane skew toward the systolic array rows.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module act_pingpong_buffer
    import act_pingpong_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = c_DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = c_DEFAULT_DEPTH,
    parameter int LANES      = c_DEFAULT_LANES,
    parameter int SKEW       = 1
) (
    input wire                   clk,
    input wire                   rst_n,
    act_pingpong_buffer_if.slave bus
);

    localparam int c_CNT_W = f_cnt_width(DEPTH);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_W     = LANES * DATA_WIDTH;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    logic [c_W-1:0]     r_mem [2][DEPTH];
    logic               r_active;
    logic [c_CNT_W-1:0] r_wr_count;
    logic [c_CNT_W-1:0] r_rd_fill;
    logic [c_CNT_W-1:0] r_rd_ptr;

    logic               w_in_ready;
    logic               w_wr_fire;
    logic               w_rd_empty;
    logic               w_swap_ack;
    logic               w_replay;
    logic               w_pop;
    logic [c_W-1:0]     w_rd_word;
    logic [DATA_WIDTH:0] w_lane_in  [LANES];
    logic [DATA_WIDTH:0] w_lane_out [LANES];
    logic [c_W-1:0]     w_out_data;
    logic [LANES-1:0]   w_out_valid;

    // Write pointer and write count are the same quantity, so one register serves both.
    assign w_in_ready = (r_wr_count < c_DEPTH);
    assign w_wr_fire  = bus.in_valid && w_in_ready;
    assign w_rd_empty = (r_rd_ptr == r_rd_fill);
    assign w_swap_ack = bus.swap_req && w_rd_empty;
    assign w_replay   = bus.replay && !w_swap_ack && (r_rd_fill != '0);
    assign w_pop      = bus.read_en && !w_rd_empty && !w_replay;
    assign w_rd_word  = r_mem[~r_active][r_rd_ptr[c_PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (w_wr_fire) r_mem[r_active][r_wr_count[c_PTR_W-1:0]] <= bus.in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active   <= 1'b0;
            r_wr_count <= '0;
            r_rd_fill  <= '0;
            r_rd_ptr   <= '0;
        end else if (w_swap_ack) begin
            // A write landing in the swap cycle belongs to the outgoing bank.
            r_active   <= ~r_active;
            r_rd_fill  <= w_wr_fire ? (r_wr_count + c_ONE) : r_wr_count;
            r_rd_ptr   <= '0;
            r_wr_count <= '0;
        end else begin
            if (w_wr_fire) r_wr_count <= r_wr_count + c_ONE;
            if (w_replay)   r_rd_ptr <= '0;
            else if (w_pop) r_rd_ptr <= r_rd_ptr + c_ONE;
        end
    end

    // Non-pop cycles inject a zero bubble so the free-running lanes stay aligned.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        localparam int c_STAGES = (SKEW != 0) ? (g + 1) : 1;

        assign w_lane_in[g] = w_pop ? {1'b1, w_rd_word[g*DATA_WIDTH +: DATA_WIDTH]} : '0;

        act_pingpong_buffer_skew_line #(
            .N     (c_STAGES),
            .WIDTH (DATA_WIDTH + 1)
        ) u_skew (
            .clk   (clk),
            .rst_n (rst_n),
            .i_d   (w_lane_in[g]),
            .o_q   (w_lane_out[g])
        );

        assign w_out_data[g*DATA_WIDTH +: DATA_WIDTH] = w_lane_out[g][DATA_WIDTH-1:0];
        assign w_out_valid[g]                         = w_lane_out[g][DATA_WIDTH];
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.swap_ack    = w_swap_ack;
    assign bus.rd_empty    = w_rd_empty;
    assign bus.out_data    = w_out_data;
    assign bus.out_valid   = w_out_valid;
    assign bus.wr_count    = r_wr_count;
    assign bus.active_bank = r_active;

endmodule

`default_nettype wire
